// File: rtl/mem_walker_pkg.sv
// Shared definitions for the memory walker: state encoding, pattern LFSR taps and word stride.
package mem_walker_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_ISSUE = 3'd1,
        S_WR_WAIT  = 3'd2,
        S_RD_ISSUE = 3'd3,
        S_RD_WAIT  = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [31:0] LFSR_MASK   = 32'h0040_0007;
    localparam logic [31:0] WORD_STRIDE = 32'd4;

    // Galois step: left shift, taps folded in when the bit shifted out was 1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {v[30:0], 1'b0} ^ (v[31] ? LFSR_MASK : 32'h0);
    endfunction

endpackage

// File: rtl/mem_walker_lfsr32.sv
// 32-bit Galois LFSR pattern source; a zero seed is replaced by 1 so the sequence never locks up.
module lfsr32
    import mem_walker_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [31:0] seed_i,
    input  logic        adv_i,
    output logic [31:0] value_o
);

    logic [31:0] value_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_q <= 32'h0;
        end else if (load_i) begin
            value_q <= (seed_i == 32'h0) ? 32'h1 : seed_i;
        end else if (adv_i) begin
            value_q <= lfsr_step(value_q);
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/mem_walker.sv
// Memory-test initiator: writes a pattern over a word range through the cache, reads it back and compares.
// Optional MEM_WALKER_LFSR_EN selects an LFSR pattern instead of address ^ seed.
module mem_walker
    import mem_walker_pkg::*;
#(
    parameter int COUNT_BITWIDTH     = 16,
    parameter int ERR_COUNT_BITWIDTH = 16,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [31:0]                   base_address,
    input  logic [COUNT_BITWIDTH-1:0]     word_count,
    input  logic [31:0]                   seed,
    output logic                          active,
    output logic                          done,
    output logic                          pass,
    output logic [ERR_COUNT_BITWIDTH-1:0] error_count,
    output logic [31:0]                   first_error_address,
    output logic                          timeout,
    output logic [31:0]                   address,
    output logic [31:0]                   data_in,
    output logic [3:0]                    write_enable,
    input  logic [31:0]                   data_out,
    input  logic                          data_out_ready,
    input  logic                          busy
);

    localparam int          TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLOAD = TW'(TIMEOUT_CYCLES - 1);

    state_t                        state_q;
    logic [COUNT_BITWIDTH:0]       i_q, i_d;
    logic [COUNT_BITWIDTH-1:0]     count_q;
    logic [31:0]                   base_q, seed_q, addr_q, addr_d, data_q;
    logic [TW-1:0]                 tmr_q;
    logic [3:0]                    we_q;
    logic                          active_q, done_q, pass_q, timeout_q;
    logic [ERR_COUNT_BITWIDTH-1:0] err_q;
    logic [31:0]                   first_q;
    logic [31:0]                   base_start, pat_start, pat_cur, pat_d;
    logic                          wr_done, rd_done, last_w, mismatch;

    assign base_start = base_address & 32'hFFFF_FFFC;
    assign i_d        = i_q + 1'b1;
    assign addr_d     = base_q + 32'(i_d) * WORD_STRIDE;
    assign wr_done    = !busy;
    assign rd_done    = !busy && data_out_ready;
    assign last_w     = (i_d == {1'b0, count_q});

`ifdef MEM_WALKER_LFSR_EN
    logic        lfsr_load, lfsr_adv;
    logic [31:0] lfsr_val;

    assign lfsr_load = (state_q == S_IDLE && start) ||
                       (state_q == S_WR_WAIT && wr_done && last_w);
    assign lfsr_adv  = (state_q == S_WR_WAIT && wr_done && !last_w) ||
                       (state_q == S_RD_WAIT && rd_done);

    lfsr32 u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (lfsr_load),
        .seed_i  ((state_q == S_IDLE) ? seed : seed_q),
        .adv_i   (lfsr_adv),
        .value_o (lfsr_val)
    );

    assign pat_start = (seed == 32'h0) ? 32'h1 : seed;
    assign pat_cur   = lfsr_val;
    assign pat_d     = lfsr_step(lfsr_val);
`else
    assign pat_start = base_start ^ seed;
    assign pat_cur   = addr_q ^ seed_q;
    assign pat_d     = addr_d ^ seed_q;
`endif

    assign mismatch = (data_out != pat_cur);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            count_q   <= '0;
            base_q    <= 32'h0;
            seed_q    <= 32'h0;
            tmr_q     <= '0;
            addr_q    <= 32'h0;
            data_q    <= 32'h0;
            we_q      <= 4'h0;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            first_q   <= 32'h0;
            timeout_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_q    <= base_start;
                        count_q   <= word_count;
                        seed_q    <= seed;
                        i_q       <= '0;
                        pass_q    <= 1'b0;
                        err_q     <= '0;
                        first_q   <= 32'h0;
                        timeout_q <= 1'b0;
                        if (word_count == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b1;
                        end else begin
                            state_q  <= S_WR_ISSUE;
                            active_q <= 1'b1;
                            addr_q   <= base_start;
                            data_q   <= pat_start;
                            we_q     <= 4'hF;
                        end
                    end
                end
                S_WR_ISSUE: begin
                    tmr_q   <= TLOAD;
                    state_q <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (wr_done) begin
                        if (last_w) begin
                            i_q     <= '0;
                            addr_q  <= base_q;
                            we_q    <= 4'h0;
                            state_q <= S_RD_ISSUE;
                        end else begin
                            i_q     <= i_d;
                            addr_q  <= addr_d;
                            data_q  <= pat_d;
                            state_q <= S_WR_ISSUE;
                        end
                    end else if (tmr_q == '0) begin
                        timeout_q <= 1'b1;
                        we_q      <= 4'h0;
                        active_q  <= 1'b0;
                        done_q    <= 1'b1;
                        pass_q    <= 1'b0;
                        state_q   <= S_DONE;
                    end else begin
                        tmr_q <= tmr_q - TW'(1);
                    end
                end
                S_RD_ISSUE: begin
                    tmr_q   <= TLOAD;
                    state_q <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (rd_done) begin
                        if (mismatch) begin
                            if (err_q != '1) err_q <= err_q + ERR_COUNT_BITWIDTH'(1);
                            if (err_q == '0) first_q <= addr_q;
                        end
                        if (last_w) begin
                            active_q <= 1'b0;
                            done_q   <= 1'b1;
                            pass_q   <= !mismatch && (err_q == '0);
                            state_q  <= S_DONE;
                        end else begin
                            i_q     <= i_d;
                            addr_q  <= addr_d;
                            state_q <= S_RD_ISSUE;
                        end
                    end else if (tmr_q == '0) begin
                        timeout_q <= 1'b1;
                        active_q  <= 1'b0;
                        done_q    <= 1'b1;
                        pass_q    <= 1'b0;
                        state_q   <= S_DONE;
                    end else begin
                        tmr_q <= tmr_q - TW'(1);
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign active              = active_q;
    assign done                = done_q;
    assign pass                = pass_q;
    assign error_count         = err_q;
    assign first_error_address = first_q;
    assign timeout             = timeout_q;
    assign address             = addr_q;
    assign data_in             = data_q;
    assign write_enable        = we_q;

endmodule

// File: tb/tb_mem_walker.sv
// Bench for mem_walker: behavioural cache/RAM with random busy, fault injection and a word-level reference model.
module tb_mem_walker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_address = 32'h0;
    logic [15:0] word_count = 16'h0;
    logic [31:0] seed = 32'h0;
    logic        active, done, pass, timeout;
    logic [15:0] error_count;
    logic [31:0] first_error_address, address, data_in;
    logic [3:0]  write_enable;
    logic [31:0] data_out = 32'h0;
    logic        data_out_ready = 1'b0;
    logic        busy = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [logic [29:0]];
    bit          inj [logic [31:0]];
    int          busy_pct = 0;
    int          streak = 0;
    bit          hang = 1'b0;
    bit          we_seen = 1'b0;

    mem_walker #(
        .COUNT_BITWIDTH    (16),
        .ERR_COUNT_BITWIDTH(16),
        .TIMEOUT_CYCLES    (16)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .base_address       (base_address),
        .word_count         (word_count),
        .seed               (seed),
        .active             (active),
        .done               (done),
        .pass               (pass),
        .error_count        (error_count),
        .first_error_address(first_error_address),
        .timeout            (timeout),
        .address            (address),
        .data_in            (data_in),
        .write_enable       (write_enable),
        .data_out           (data_out),
        .data_out_ready     (data_out_ready),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    // Cache stand-in: a write lands when the request is seen with busy low.
    always @(posedge clk) begin
        if (write_enable != 4'h0) we_seen = 1'b1;
        if (rst_n && write_enable == 4'hF && !busy) mem[address[31:2]] = data_in;
    end

    always @(negedge clk) begin
        logic [31:0] d;
        if (hang) begin
            busy = 1'b1;
        end else if (streak >= 6) begin
            busy = 1'b0;
        end else begin
            busy = ($urandom_range(0, 99) < busy_pct);
        end
        streak = busy ? streak + 1 : 0;
        data_out_ready = !busy;
        d = mem.exists(address[31:2]) ? mem[address[31:2]] : 32'h0;
        if (write_enable == 4'h0 && inj.exists(address)) d = d ^ 32'h1;
        data_out = d;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] p);
        return {p[30:0], 1'b0} ^ (p[31] ? 32'h0040_0007 : 32'h0);
    endfunction

    // One complete test; expectations come from the word-level model below.
    task automatic run_test(input string tag, input logic [31:0] b, input int c, input logic [31:0] s,
                            input int pct, input bit poke, input int inj_a, input int inj_b);
        logic [31:0] exp_addr [$];
        logic [31:0] exp_pat  [$];
        logic [31:0] a, p, exp_first;
        int          exp_err, cyc, limit;
        bit          first_found;

        mem.delete();
        inj.delete();
        busy_pct = pct;
        exp_err = 0;
        exp_first = 32'h0;
        first_found = 1'b0;
`ifdef MEM_WALKER_LFSR_EN
        p = (s == 32'h0) ? 32'h1 : s;
`endif
        for (int i = 0; i < c; i++) begin
            a = {b[31:2], 2'b00} + 32'(i) * 32'd4;
`ifndef MEM_WALKER_LFSR_EN
            p = a ^ s;
`endif
            exp_addr.push_back(a);
            exp_pat.push_back(p);
`ifdef MEM_WALKER_LFSR_EN
            p = ref_next(p);
`endif
            if (i == inj_a || i == inj_b) begin
                inj[a] = 1'b1;
                exp_err++;
                if (!first_found) begin
                    exp_first = a;
                    first_found = 1'b1;
                end
            end
        end

        we_seen = 1'b0;
        @(negedge clk);
        base_address = b;
        word_count = 16'(c);
        seed = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (c != 0) begin
            check_val({tag, " active_at_start"}, 32'(active), 32'h1);
            check_val({tag, " first_we"}, 32'(write_enable), 32'hF);
            check_val({tag, " first_addr"}, address, exp_addr[0]);
        end
        cyc = 0;
        limit = 40 * c + 40;
        while (!done && cyc < limit) begin
            if (poke && cyc == 3) begin
                start = 1'b1;
                base_address = ~b;
                word_count = 16'h0;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end
        check_val({tag, " done_seen"}, 32'(done), 32'h1);
        if (pct == 0 && !poke) check_val({tag, " latency"}, 32'(cyc), 32'(4 * c));
        check_val({tag, " pass"}, 32'(pass), (exp_err == 0) ? 32'h1 : 32'h0);
        check_val({tag, " error_count"}, 32'(error_count), 32'(exp_err));
        check_val({tag, " first_err"}, first_error_address, exp_first);
        check_val({tag, " timeout"}, 32'(timeout), 32'h0);
        check_val({tag, " active_end"}, 32'(active), 32'h0);
        if (c == 0) check_val({tag, " we_never"}, 32'(we_seen), 32'h0);
        for (int i = 0; i < c; i++) begin
            a = exp_addr[i];
            check_val({tag, " ram"}, mem.exists(a[31:2]) ? mem[a[31:2]] : 32'hxxxx_xxxx, exp_pat[i]);
        end
        @(posedge clk);
        #1;
        check_val({tag, " done_pulse"}, 32'(done), 32'h0);
        check_val({tag, " pass_hold"}, 32'(pass), (exp_err == 0) ? 32'h1 : 32'h0);
        inj.delete();
    endtask

    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst address", address, 32'h0);
        check_val("rst data_in", data_in, 32'h0);
        check_val("rst we", 32'(write_enable), 32'h0);
        check_val("rst active", 32'(active), 32'h0);
        check_val("rst done", 32'(done), 32'h0);
        check_val("rst pass", 32'(pass), 32'h0);
        check_val("rst err", 32'(error_count), 32'h0);
        check_val("rst first", first_error_address, 32'h0);
        check_val("rst timeout", 32'(timeout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_test("basic",  32'h0000_0000, 4,  32'h0000_0001, 0,  1'b0, -1, -1);
        run_test("full",   32'h0000_0000, 32, 32'hDEAD_BEEF, 40, 1'b0, -1, -1);
        run_test("inject", 32'h0000_0000, 4,  32'h0000_0001, 0,  1'b0, 2,  -1);
        run_test("wrap",   32'hFFFF_FFFB, 4,  32'h1234_5678, 25, 1'b0, 3,  1);
        run_test("zero",   32'h0000_0040, 0,  32'hCAFE_F00D, 0,  1'b0, -1, -1);
        run_test("poke",   32'h0000_0100, 6,  32'hA5A5_5A5A, 20, 1'b1, -1, -1);

        for (int t = 0; t < 6; t++) begin
            int c, ia, ib;
            c  = $urandom_range(2, 24);
            ia = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, c - 1);
            ib = ($urandom_range(0, 2) == 0) ? $urandom_range(0, c - 1) : -1;
            run_test("rand", $urandom, c, $urandom, $urandom_range(0, 60), t[0], ia, ib);
        end

        // Cache stuck busy: access must time out and abandon the test.
        hang = 1'b1;
        @(negedge clk);
        base_address = 32'h0;
        word_count = 16'd5;
        seed = 32'h1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_val("to done_seen", 32'(done), 32'h1);
        check_val("to within_18", 32'(cyc <= 18), 32'h1);
        check_val("to timeout", 32'(timeout), 32'h1);
        check_val("to pass", 32'(pass), 32'h0);
        check_val("to we", 32'(write_enable), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_val("to we_after", 32'(write_enable), 32'h0);
        check_val("to timeout_hold", 32'(timeout), 32'h1);

        // Reset while a write is waiting on the cache.
        @(negedge clk);
        base_address = 32'h0000_0020;
        word_count = 16'd4;
        seed = 32'h5555_AAAA;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_val("mid we_busy", 32'(write_enable), 32'hF);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_val("mid address", address, 32'h0);
        check_val("mid data_in", data_in, 32'h0);
        check_val("mid we", 32'(write_enable), 32'h0);
        check_val("mid active", 32'(active), 32'h0);
        check_val("mid timeout", 32'(timeout), 32'h0);
        check_val("mid pass", 32'(pass), 32'h0);
        check_val("mid err", 32'(error_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        hang = 1'b0;
        run_test("restart", 32'h0000_0010, 4, 32'hFFFF_0000, 30, 1'b0, -1, -1);
`ifndef MEM_WALKER_LFSR_EN
        check_val("restart word16", mem.exists(30'd4) ? mem[30'd4] : 32'h0, 32'hFFFF_0010);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
